demux14_router: RTL

//  1:4 stream demultiplexer: the inverse of the team's 4:1 mux. One 8-bit input stream is routed to one
//  of four output channels by iSEL, with a valid/ready handshake on every side.

---
 rtl/demux14_pkg.sv | 13 +
 rtl/demux14_slot.sv | 33 +++
 rtl/demux14_router.sv | 106 ++++++++++
 3 files changed

// File: rtl/demux14_pkg.sv
// rtl/demux14_pkg.sv - shared types and constants for the 1:4 stream router
package demux14_pkg;

    localparam int NCH = 4;

    typedef logic [1:0] chan_t;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_e;

endpackage

// File: rtl/demux14_slot.sv
// rtl/demux14_slot.sv - one-entry output register slice with refill-on-drain
module demux14_slot
    import demux14_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_last,
    input  logic          rd,
    output logic [DW-1:0] tdata,
    output logic          tlast,
    output logic          tvalid
);

    // Write wins over drain so a simultaneous drain+fill keeps the slot full with the new beat
    always_ff @(posedge clk) begin
        if (rst) begin
            tdata  <= '0;
            tlast  <= 1'b0;
            tvalid <= 1'b0;
        end else if (wr) begin
            tdata  <= wr_data;
            tlast  <= wr_last;
            tvalid <= 1'b1;
        end else if (tvalid && rd) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux14_router.sv
// rtl/demux14_router.sv - packet-aware 1:4 stream demultiplexer with per-channel beat counters
module demux14_router
    import demux14_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  up_tdata,
    input  logic           up_tlast,
    input  logic           up_tvalid,
    output logic           up_tready,
    input  logic [1:0]     sel,
    output logic [DW-1:0]  a_tdata,
    output logic [DW-1:0]  b_tdata,
    output logic [DW-1:0]  c_tdata,
    output logic [DW-1:0]  d_tdata,
    output logic [NCH-1:0] ch_tlast,
    output logic [NCH-1:0] ch_tvalid,
    input  logic [NCH-1:0] ch_tready,
    output logic [CW-1:0]  cnt0,
    output logic [CW-1:0]  cnt1,
    output logic [CW-1:0]  cnt2,
    output logic [CW-1:0]  cnt3,
    output logic           busy
);

    state_e         state;
    chan_t          lock_ch;
    chan_t          ch;
    logic           accept;
    logic [NCH-1:0] full;
    logic [NCH-1:0] wr;
    logic [DW-1:0]  slot_data [NCH];
    logic [CW-1:0]  cnt [NCH];

    // Mid-packet the latched channel overrides sel so a packet never splits across outputs
    assign ch        = (state == ST_LOCKED) ? lock_ch : chan_t'(sel);
    assign up_tready = !full[ch] | ch_tready[ch];
    assign accept    = up_tvalid & up_tready;
    assign busy      = (state == ST_LOCKED);
    assign ch_tvalid = full;

    // Steer the accepted beat into exactly one slot
    always_comb begin
        wr     = '0;
        wr[ch] = accept;
    end

    // Packet framing: latch the channel on a non-last first beat, release on the accepted last beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            lock_ch <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && !up_tlast) begin
                        state   <= ST_LOCKED;
                        lock_ch <= chan_t'(sel);
                    end
                end
                ST_LOCKED: begin
                    if (accept && up_tlast) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        demux14_slot #(.DW(DW)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .wr      (wr[k]),
            .wr_data (up_tdata),
            .wr_last (up_tlast),
            .rd      (ch_tready[k]),
            .tdata   (slot_data[k]),
            .tlast   (ch_tlast[k]),
            .tvalid  (full[k])
        );

        // Count delivered beats, sticking at all-ones instead of wrapping
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt[k] <= '0;
            end else if (full[k] && ch_tready[k] && (cnt[k] != '1)) begin
                cnt[k] <= cnt[k] + 1'b1;
            end
        end
    end

    assign a_tdata = slot_data[0];
    assign b_tdata = slot_data[1];
    assign c_tdata = slot_data[2];
    assign d_tdata = slot_data[3];
    assign cnt0    = cnt[0];
    assign cnt1    = cnt[1];
    assign cnt2    = cnt[2];
    assign cnt3    = cnt[3];

endmodule
